// File: rtl/sram_initiator_if.sv
// Request/response side of the SRAM initiator, plus debug visibility of its FSM.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_* are ignored otherwise.
interface sram_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        busy;
    logic [1:0]  dbg_state;
    logic        dbg_drive;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data, busy, dbg_state, dbg_drive
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data, busy, dbg_state, dbg_drive
    );
endinterface

// File: rtl/sram_initiator.sv
// Single-transaction initiator for a 16-bit asynchronous SRAM: sequences address setup,
// an active-low oe/we strobe and hold phase, and captures read data as the strobe rises.
module sram_initiator #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              reset,
    sram_initiator_if.slave   req_if,
    output logic [15:0]       addr,
    output logic              oe,
    output logic              we,
    inout  wire  [15:0]       data_io
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        write_q;
    logic        oe_q;
    logic        we_q;
    logic        drive_q;
    logic [15:0] rd_data_q;
    logic        rd_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'd0;
            wdata_q    <= 16'd0;
            write_q    <= 1'b0;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            drive_q    <= 1'b0;
            rd_data_q  <= 16'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_if.req_valid) begin
                        addr_q  <= req_if.req_addr;
                        write_q <= req_if.req_write;
                        drive_q <= req_if.req_write;
                        if (req_if.req_write) begin
                            wdata_q <= req_if.req_wdata;
                        end
                        cnt_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q   <= PULSE_LD;
                        state_q <= PULSE;
                        if (write_q) begin
                            we_q <= 1'b0;
                        end else begin
                            oe_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q   <= HOLD_LD;
                        state_q <= HOLD;
                        oe_q    <= 1'b1;
                        we_q    <= 1'b1;
                        // Sample the bus while oe is still low on this edge.
                        if (!write_q) begin
                            rd_data_q  <= data_io;
                            rd_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        drive_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_if.req_ready = (state_q == IDLE) && !reset;
    assign req_if.rd_valid  = rd_valid_q;
    assign req_if.rd_data   = rd_data_q;
    assign req_if.busy      = (state_q != IDLE);
    assign req_if.dbg_state = state_q;
    assign req_if.dbg_drive = drive_q;

    assign addr    = addr_q;
    assign oe      = oe_q;
    assign we      = we_q;
    assign data_io = drive_q ? wdata_q : 16'hzzzz;
endmodule

// File: tb/tb_sram_initiator.sv
// Bench for sram_initiator: two instances (default timing and S=3/P=1/H=2), each with a d_mem-style SRAM model.
module tb_sram_initiator;
    localparam int S0 = 1, P0 = 2, H0 = 1;
    localparam int S1 = 3, P1 = 1, H1 = 2;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [15:0] req_wdata = 16'd0;

    sram_initiator_if ifc0 ();
    sram_initiator_if ifc1 ();

    assign ifc0.req_valid = req_valid & ~sel;
    assign ifc0.req_write = req_write;
    assign ifc0.req_addr  = req_addr;
    assign ifc0.req_wdata = req_wdata;
    assign ifc1.req_valid = req_valid & sel;
    assign ifc1.req_write = req_write;
    assign ifc1.req_addr  = req_addr;
    assign ifc1.req_wdata = req_wdata;

    wire [15:0] addr0, addr1, dio0, dio1;
    wire        oe0, we0, oe1, we1;

    sram_initiator #(.SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0)) dut0 (
        .clk(clk), .reset(reset), .req_if(ifc0),
        .addr(addr0), .oe(oe0), .we(we0), .data_io(dio0)
    );

    sram_initiator #(.SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1)) dut1 (
        .clk(clk), .reset(reset), .req_if(ifc1),
        .addr(addr1), .oe(oe1), .we(we1), .data_io(dio1)
    );

    // SRAM models: latch on falling we, drive while oe is low
    logic [15:0] mem0 [65536];
    logic [15:0] mem1 [65536];
    always @(negedge we0) mem0[addr0] = dio0;
    always @(negedge we1) mem1[addr1] = dio1;
    assign dio0 = oe0 ? 16'hzzzz : mem0[addr0];
    assign dio1 = oe1 ? 16'hzzzz : mem1[addr1];

    // view of the selected instance
    wire        m_ready = sel ? ifc1.req_ready : ifc0.req_ready;
    wire        m_busy  = sel ? ifc1.busy      : ifc0.busy;
    wire        m_rdv   = sel ? ifc1.rd_valid  : ifc0.rd_valid;
    wire        m_drive = sel ? ifc1.dbg_drive : ifc0.dbg_drive;
    wire        m_oe    = sel ? oe1 : oe0;
    wire        m_we    = sel ? we1 : we0;
    wire [15:0] m_addr  = sel ? addr1 : addr0;
    wire [15:0] m_dio   = sel ? dio1 : dio0;

    // scoreboard
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int last_t0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // per-cycle bus invariants and read-data scoreboard
    always @(negedge clk) begin
        logic [15:0] e;
        check("strobe_overlap0", !oe0 && !we0, 0);
        check("strobe_overlap1", !oe1 && !we1, 0);
        check("drive_vs_oe0", ifc0.dbg_drive && !oe0, 0);
        check("drive_vs_oe1", ifc1.dbg_drive && !oe1, 0);
        if (ifc0.rd_valid || ifc1.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", ifc0.rd_valid ? ifc0.rd_data : ifc1.rd_data, e);
            end
        end
    end

    // driver: called at a negedge; returns at the negedge of the first IDLE cycle after the transaction
    task automatic txn(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit keep, input bit chk_gap);
        int s, p, h;
        bit ok;
        bit strobe;
        s = sel ? S1 : S0;
        p = sel ? P1 : P0;
        h = sel ? H1 : H0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        if (!w) exp_q.push_back(d);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            if (!w) void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        // scrambled inputs while busy must be ignored
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        for (int k = 1; k <= s + p + h + 1; k++) begin
            @(negedge clk);
            strobe = (k > s) && (k <= s + p);
            if (k == 1) begin
                if (chk_gap) check("accept_spacing", cyc - last_t0, 1 + s + p + h);
                last_t0 = cyc;
            end
            check("busy", m_busy, k <= s + p + h);
            check("oe", m_oe, !(strobe && !w));
            check("we", m_we, !(strobe && w));
            check("drive", m_drive, w && (k <= s + p + h));
            check("addr", m_addr, a);
            if (w && k <= s + p + h) check("data_io", m_dio, d);
            check("rd_valid", m_rdv, !w && (k == s + p + 1));
            check("req_ready", m_ready, k == s + p + h + 1);
        end
        if (!keep) req_valid = 1'b0;
    endtask

    logic [15:0] ref_mem [4];

    initial begin
        logic [15:0] d;
        int idx;
        bit prev_keep;
        bit keep;

        // reset and idle
        repeat (3) @(negedge clk);
        check("ready_in_reset", ifc0.req_ready, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_oe", oe0, 1);
        check("idle_we", we0, 1);
        check("idle_drive", ifc0.dbg_drive, 0);
        check("idle_ready", ifc0.req_ready, 1);
        check("idle_busy", ifc0.busy, 0);
        check("idle_rd_valid", ifc0.rd_valid, 0);
        check("idle_addr", addr0, 0);
        check("idle_rd_data", ifc0.rd_data, 0);
        check("idle_ready1", ifc1.req_ready, 1);
        check("idle_oe_we1", {oe1, we1}, 2'b11);

        // basic write then read-back
        txn(1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0);
        txn(1'b0, 16'h1234, 16'hBEEF, 1'b0, 1'b0);

        // wrap-around addresses, back-to-back with req_valid held high
        txn(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        txn(1'b1, 16'h0000, 16'h0001, 1'b1, 1'b1);
        txn(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        txn(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1);

        // random traffic over a small address window
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = 16'($urandom);
            txn(1'b1, 16'h0100 + 16'(i), ref_mem[i], 1'b0, 1'b0);
        end
        prev_keep = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idx  = $urandom_range(0, 3);
            keep = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                ref_mem[idx] = d;
                txn(1'b1, 16'h0100 + 16'(idx), d, keep, prev_keep);
            end else begin
                txn(1'b0, 16'h0100 + 16'(idx), ref_mem[idx], keep, prev_keep);
            end
            prev_keep = keep;
        end
        req_valid = 1'b0;
        @(negedge clk);

        // alternate timing instance
        sel = 1'b1;
        txn(1'b1, 16'h00A5, 16'h5A5A, 1'b1, 1'b0);
        txn(1'b0, 16'h00A5, 16'h5A5A, 1'b1, 1'b1);
        txn(1'b0, 16'h00A5, 16'h5A5A, 1'b0, 1'b1);
        @(negedge clk);
        sel = 1'b0;

        // reset in the middle of a read strobe
        check("abort_ready", ifc0.req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_setup_state", ifc0.dbg_state, 1);
        @(negedge clk);
        check("abort_oe_low", oe0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_oe", oe0, 1);
        check("abort_we", we0, 1);
        check("abort_state", ifc0.dbg_state, 0);
        check("abort_drive", ifc0.dbg_drive, 0);
        check("abort_busy", ifc0.busy, 0);
        check("abort_rd_valid", ifc0.rd_valid, 0);
        check("abort_ready_low", ifc0.req_ready, 0);
        check("abort_addr", addr0, 0);
        check("abort_rd_data", ifc0.rd_data, 0);
        reset = 1'b0;
        #1;
        check("abort_ready_back", ifc0.req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rd_valid", ifc0.rd_valid, 0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_initiator.md
# sram_initiator

Clocked initiator for the 16-bit asynchronous SRAM port: it turns single-cycle read/write requests from buffer logic into correctly sequenced active-low `oe`/`we` strobes, address and tri-stated data on the SRAM bus. It is the controller-side counterpart of the SRAM model `d_mem`, which latches write data on the falling edge of `we` and drives read data while `oe` is low. It sits between the single-buffer datapath and the external or modelled SRAM. One transaction is in flight at a time, with programmable setup, strobe and hold phases.

## Interface
Parameters:
- `SETUP_CYC`, default 1, range 1..15: cycles that address (and write data) are stable before the strobe falls.
- `PULSE_CYC`, default 2, range 1..15: cycles the strobe is held low.
- `HOLD_CYC`, default 1, range 1..15: cycles that address (and write data) are held after the strobe rises.

Ports:
- `clk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; equals (state==IDLE) && !reset.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 16: word address.
- `req_wdata` in 16: write data.
- `rd_valid` out 1: one-cycle pulse; `rd_data` is valid.
- `rd_data` out 16: captured read word, held until the next read completes.
- `busy` out 1: state != IDLE.
- `addr` out 16: SRAM address.
- `oe` out 1: SRAM output enable, active-low.
- `we` out 1: SRAM write enable, active-low.
- `data_io` inout 16: SRAM data bus, tri-stated unless this block is writing.

## Operation
- States: IDLE, SETUP, PULSE, HOLD. The phase counter is 4 bits, loaded with N-1 on entry to each phase; the phase exits when the counter is 0.
- IDLE: on `req_valid && req_ready`, register `req_addr` into `addr`. On a write, also register `req_wdata` into the write-data register and set the write flag. Go to SETUP.
- SETUP → PULSE: after SETUP_CYC cycles. `oe` (read) or `we` (write) goes low, registered, on the entering edge.
- PULSE → HOLD: after PULSE_CYC cycles. On the exiting edge the strobe returns high.
  - Read: on that same edge, `rd_data` <= `data_io` and `rd_valid` <= 1 for exactly one cycle.
- HOLD → IDLE: after HOLD_CYC cycles. `addr` keeps its last value in IDLE.
- Data bus drive enable:
  - High only for a write, from entry into SETUP through the last HOLD cycle.
  - Never high while `oe` is low.
  - Never high during a read or in IDLE.
- `oe` and `we` are never low in the same cycle.
- Requests while busy are not accepted; `req_*` inputs are ignored unless the handshake fires.
- Reset (any state, including mid-pulse), effective at the next edge:
  - state IDLE, `oe`=`we`=1, bus tri-stated.
  - `addr`=0, `rd_data`=0, `rd_valid`=0, `busy`=0.
  - `req_ready`=0 while `reset` is high; 1 on the first cycle after reset deasserts.
  - An aborted write may or may not have been committed by the SRAM; an aborted read produces no `rd_valid`.

## Timing
- Accept at edge T0. SETUP covers cycles T0+1 .. T0+S. Strobe is low for cycles T0+S+1 .. T0+S+P. HOLD covers cycles T0+S+P+1 .. T0+S+P+H. Back in IDLE at T0+S+P+H+1.
- Read latency: `rd_valid` is high in cycle T0+S+P+1 (defaults: 4 cycles after the accept edge).
- Throughput: one transaction per 1+S+P+H cycles (defaults: 5). `req_ready` is low from T0+1 until IDLE is re-entered.
- Write data is stable on `data_io` at least S cycles before `we` falls and H cycles after it rises.
- All outputs are registered except `req_ready`, which is combinational from state and `reset`.

## Test plan
- Reset, then idle 3 cycles → `oe`=`we`=1, `data_io`=Z, `req_ready`=1, `busy`=0, `rd_valid`=0.
- Write 0xBEEF to 0x1234 (defaults) → `addr`=0x1234 from T0+1; `data_io`=0xBEEF for cycles T0+1..T0+4; `we` low exactly in T0+2..T0+3; `oe` never low.
- Read back 0x1234 against the `d_mem` model → `oe` low in T0+2..T0+3; `rd_valid` pulses once at T0+4 with `rd_data`=0xBEEF; bus never driven by the initiator.
- Wrap-around and back-to-back: write 0xFFFF→addr 0xFFFF, then 0x0001→addr 0x0000, then read both with `req_valid` held high → each accept spaced 5 cycles, reads return 0xFFFF and 0x0001, no strobe overlap.
- Parameter sweep S=3, P=1, H=2: strobe low exactly 1 cycle; `rd_valid` at T0+5; next accept at T0+7.
- Assert `reset` in the middle of the PULSE phase of a read → next edge `oe`=1, state IDLE, no `rd_valid`; `req_ready` returns 1 the cycle after `reset` falls.
